// File: rtl/rom_arbiter.sv
// rom_arbiter
// -----------------------------------------------------------------------------
// Round-robin arbiter that shares one synchronous read-only table between
// NUM_REQ requesters. At most one read is issued per cycle. A short valid/tag
// pipeline follows each read through the table, so the registered result goes
// back only to the requester that issued it. Each requester may have only one
// read in flight, and the response latency is always three cycles after accept.
//
// Ports
//   clk        : single clock, all state changes on the rising edge
//   reset      : asynchronous, active-low; clears all state at once
//   req_valid  : per-requester read request
//   req_addr   : request addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_ready  : one-hot grant; a request is accepted when valid & ready
//   rsp_valid  : one-hot, one-cycle pulse naming the owner of rsp_data
//   rsp_data   : returned table word, shared by all requesters
//   rom_addr   : table address (registered)
//   rom_read   : table read enable (registered)
//   rom_data   : table output, valid the cycle after rom_read was high
//   busy       : at least one read is in flight
// -----------------------------------------------------------------------------
module rom_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [WIDTH-1:0]              rsp_data,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    output logic                          rom_read,
    input  logic [WIDTH-1:0]              rom_data,
    output logic                          busy
);

    localparam int TAG_W = $clog2(NUM_REQ);

    typedef logic [TAG_W-1:0] tag_t;

    logic [NUM_REQ-1:0] pending;   // requester has a read in flight
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    tag_t               ptr;       // highest-priority index for the next search
    tag_t               win;       // index of the current winner
    tag_t               ptr_next;
    logic               accept;

    tag_t               tag1;      // owner of the read now on rom_addr
    logic               v2;        // table output is valid next cycle
    tag_t               tag2;      // owner of that table output

    // A requester that already has a read in flight cannot ask again until its
    // response has gone out.
    assign eligible = req_valid & ~pending;

    // -------------------------------------------------------------------------
    // Grant: search upward from ptr with wrap-around and take the first
    // eligible index. The grant does not depend on anything in the pipeline.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default before the search, so
        // no path through this block can leave a value held (no latch).
        grant = '0;
        win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant == '0 && eligible[(int'(ptr) + k) % NUM_REQ]) begin
                grant[(int'(ptr) + k) % NUM_REQ] = 1'b1;
                win = tag_t'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end

    // No grant is shown while reset is held. Once reset is released the first
    // grant can be accepted in the first cycle.
    assign req_ready = reset ? grant : '0;
    assign accept    = |req_ready;

    // The pointer moves to the index just after the winner.
    assign ptr_next  = (win == tag_t'(NUM_REQ - 1)) ? '0 : win + tag_t'(1);

    assign busy      = |pending;

    // -------------------------------------------------------------------------
    // Arbitration state: pointer and per-requester in-flight bits.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr     <= '0;
            pending <= '0;
        end else begin
            // NOTE: all state uses non-blocking assignment, so every register
            // in this file samples the values from before the edge.
            if (accept) begin
                ptr <= ptr_next;
            end
            // The accepted requester is never the one whose response is going
            // out this cycle, because a pending requester cannot be granted.
            pending <= (pending | req_ready) & ~rsp_valid;
        end
    end

    // -------------------------------------------------------------------------
    // S1 issue: drive the table address and read enable for the winner.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rom_read <= 1'b0;
            rom_addr <= '0;
            tag1     <= '0;
        end else begin
            rom_read <= accept;
            if (accept) begin
                rom_addr <= req_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
                tag1     <= win;
            end
        end
    end

    // -------------------------------------------------------------------------
    // S2 wait: the table registers its output during this stage.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v2   <= 1'b0;
            tag2 <= '0;
        end else begin
            v2   <= rom_read;
            tag2 <= tag1;
        end
    end

    // -------------------------------------------------------------------------
    // S3 capture: register the table word and pulse the owner's rsp_valid.
    // rom_data is undefined when no read was made, so it is sampled only
    // behind v2.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else if (v2) begin
            rsp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << tag2;
            rsp_data  <= rom_data;
        end else begin
            rsp_valid <= '0;
        end
    end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Round-robin arbiter that shares a single synchronous read-only table (registered output, one-cycle read latency, data undefined/high-Z when not read) between NUM_REQ requesters. Sits between requester ports and the table, issues at most one read per cycle, tracks which requester owns each in-flight read, and returns the registered result to that requester only. Each requester has at most one outstanding read, so sustained throughput is one read per cycle with four or more active requesters.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- WIDTH, 8, table data width
- DEPTH, 256, table entries
- ADDR_WIDTH, $clog2(DEPTH), table address width
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; reset=0 clears all state immediately
- req_valid  in  NUM_REQ  per-requester read request
- req_addr  in  NUM_REQ*ADDR_WIDTH  request addresses, requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_ready  out  NUM_REQ  one-hot grant; request i accepted in a cycle where req_valid[i] & req_ready[i]
- rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse: rsp_data belongs to requester i
- rsp_data  out  WIDTH  returned table word, shared by all requesters
- rom_addr  out  ADDR_WIDTH  table address (registered)
- rom_read  out  1  table read enable (registered)
- rom_data  in  WIDTH  table output, valid the cycle after rom_read was high
- busy  out  1  any request in flight (pending bit set)

## Operation
- pending[i]: set at end of accept cycle of requester i, cleared at end of its rsp_valid cycle. eligible[i] = req_valid[i] & ~pending[i].
- Grant (combinational): first eligible index searching upward from ptr, wrapping modulo NUM_REQ. req_ready = one-hot of winner, all-zero if none eligible. req_ready never depends on anything but req_valid, pending, ptr.
- ptr: on accept of index w, ptr <= (w+1) mod NUM_REQ; unchanged when no accept. Reset value 0.
- Pipeline, three registered stages with valid + tag (log2 requester index):
  - S1 (issue): on accept, rom_addr <= req_addr[w], rom_read <= 1, tag1 <= w; else rom_read <= 0, rom_addr holds.
  - S2 (wait): v2 <= rom_read, tag2 <= tag1; table registers its output this cycle.
  - S3 (capture): if v2, rsp_data <= rom_data, rsp_valid <= one-hot(tag2); else rsp_valid <= 0, rsp_data holds. rom_data is never sampled when v2=0.
- No response backpressure: requester must take rsp_data in the rsp_valid cycle.
- Requester deasserting req_valid before grant drops the request with no effect; after accept the response always returns.
- busy = |pending.
- Reset (asynchronous assertion at any time, including with reads in flight): pending=0, ptr=0, rom_read=0, rom_addr=0, v2=0, rsp_valid=0, rsp_data=0, tags=0. In-flight reads are discarded, no rsp_valid after release. req_ready=0 while reset=0. First grant possible in the first cycle after release.

## Timing
- Accept in cycle A -> rom_read=1 with address in A+1 -> rom_data valid in A+2 -> rsp_valid[w]=1, rsp_data valid in A+3. Fixed latency 3 cycles, no variation.
- pending[w] clears at end of A+3; same requester earliest re-accept in A+4 (one read per 4 cycles per requester).
- With all NUM_REQ>=4 requesters continuously valid: accept every cycle, order 0,1,2,3,0,... from reset; rsp_valid every cycle from cycle 3 on.
- Simultaneous accept and response to different requesters in one cycle is normal; response and re-request by the same requester in one cycle: request not eligible (pending still set).

## Test plan
- Identity-content table model (entry n = n). Single read: requester 2 asserts addr 0x5A in cycle A -> req_ready[2]=1 in A, rom_read=1/rom_addr=0x5A in A+1, rsp_valid=4'b0100, rsp_data=0x5A in A+3, busy high A+1..A+3.
- All four requesters valid continuously, addrs 0x10,0x11,0x12,0x13 -> grants 0,1,2,3,0,... one per cycle; rsp_data sequence 0x10,0x11,0x12,0x13 repeating with matching one-hot rsp_valid, no gaps.
- Requester 1 alone valid continuously with addr 0xFF -> accepts every 4th cycle, rsp_data=0xFF each time, rom_read duty 1/4, never sampled rom_data (driven X/Z by model) when rom_read was low in prior cycle.
- Fairness after ptr update: requesters 0 and 3 valid, ptr=2 -> 3 granted first, then 0; ptr ends at 1.
- Reset asserted in cycle A+2 of a read -> all outputs 0 immediately, no rsp_valid after release, busy=0, next grant to lowest eligible index starting from 0.
- Requester withdraws req_valid while another holds grant -> never granted, no response, pending stays 0.
